// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and width helpers for the UART TX arbiter.
// Optional feature macro: UART_ARB_PRIORITY_EN (requester 0 preempts arbitration).
package uart_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/FIFO-side bundle for the UART TX arbiter.
// master = arbiter, slave = requesters plus the TX FIFO flow control.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DBIT    = 8
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*DBIT-1:0] req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      ack;
  logic                    tx_full;
  logic                    wr_uart;
  logic [DBIT-1:0]         w_data;

  modport master (input req, req_data, req_last, tx_full, output ack, wr_uart, w_data);
  modport slave  (output req, req_data, req_last, tx_full, input ack, wr_uart, w_data);
endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin pick: first set req at rr_ptr, rr_ptr+1, ... (wrapping).
// With UART_ARB_PRIORITY_EN, requester 0 wins whenever it requests.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = int'(rr_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;  // explicit wrap, NUM_REQ need not be a power of 2
      if (!found && req[IW'(c)]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
`ifdef UART_ARB_PRIORITY_EN
    if (req[0]) begin
      found = 1'b1;
      idx   = '0;
    end
`endif
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO among NUM_REQ byte producers,
// with bursts capped at MAX_BURST bytes. Optional macro: UART_ARB_PRIORITY_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DBIT      = 8,
  parameter  int MAX_BURST = 4,
  localparam int IW        = idx_w(NUM_REQ),
  localparam int CW        = cnt_w(MAX_BURST)
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.master   bus,
  output logic [IW-1:0]       grant_id,
  output logic                busy
);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            fire;
  logic [DBIT-1:0] owner_data;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign owner_data = bus.req_data[owner_q*DBIT +: DBIT];
  // tx_full gates the strobe in the same cycle, so a full FIFO never sees a write
  assign fire       = (state_q == GRANT) & bus.req[owner_q] & ~bus.tx_full;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (fire) burst_cnt_d = burst_cnt_q + 1'b1;
        // last byte, burst cap and an abandoned request all collapse into one release
        if (!bus.req[owner_q] ||
            (fire && (bus.req_last[owner_q] || burst_cnt_q == CW'(MAX_BURST - 1)))) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ack          = '0;
    bus.ack[owner_q] = fire;
    bus.wr_uart      = fire;
    bus.w_data       = (state_q == GRANT) ? owner_data : '0;
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: producers feed byte queues, expected
// writes are queued at stimulus time and popped as wr_uart strobes appear.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int DBIT      = 8;
  localparam int MAX_BURST = 4;
  localparam int IW        = 2;

  typedef struct packed { logic [DBIT-1:0] data; logic last; } byte_t;
  typedef struct packed { logic [IW-1:0] id; logic [DBIT-1:0] data; } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] grant_id;
  logic          busy;

  byte_t              pq [NUM_REQ][$];
  exp_t               exp_q [$];
  logic [NUM_REQ-1:0] ack_seen = '0;
  int                 n_cmp = 0;
  int                 n_bad = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DBIT(DBIT)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DBIT(DBIT), .MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic void drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pq[i].size() > 0) begin
        bus.req[i]                  = 1'b1;
        bus.req_data[i*DBIT +: DBIT] = pq[i][0].data;
        bus.req_last[i]             = pq[i][0].last;
      end else begin
        bus.req[i]                  = 1'b0;
        bus.req_data[i*DBIT +: DBIT] = '0;
        bus.req_last[i]             = 1'b0;
      end
    end
  endfunction

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (bus.wr_uart) begin
        if (bus.tx_full) begin
          n_bad++;
          $display("FAIL sb_full_write: wr_uart=1 while tx_full=1, required no write");
        end else if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_extra: unexpected write id=%0d data=%02h, required none", grant_id, bus.w_data);
        end else begin
          exp_t e;
          logic [NUM_REQ-1:0] oh;
          e = exp_q.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          if (bus.w_data !== e.data || grant_id !== e.id || bus.ack !== oh) begin
            n_bad++;
            $display("FAIL sb_write: got id=%0d data=%02h ack=%b, required id=%0d data=%02h ack=%b",
                     grant_id, bus.w_data, bus.ack, e.id, e.data, oh);
          end
        end
      end else if (bus.ack !== '0) begin
        n_bad++;
        $display("FAIL sb_ack_idle: ack=%b without write, required 0", bus.ack);
      end
      ack_seen = bus.ack;
    end
  end

  // Producers: retire an acked byte just after the accepting edge
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (ack_seen[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    end
    ack_seen = '0;
    drive_reqs();
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push_msg(input int id, input int base, input int n, input bit last, input bit to_sb);
    for (int k = 0; k < n; k++) begin
      byte_t b;
      b.data = DBIT'(base + k);
      b.last = last && (k == n - 1);
      pq[id].push_back(b);
      if (to_sb) begin
        exp_t e;
        e.id   = IW'(id);
        e.data = DBIT'(base + k);
        exp_q.push_back(e);
      end
    end
    drive_reqs();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    exp_q.delete();
    drive_reqs();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.tx_full = 1'b0;
    clear_all();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic check_drained(input string name);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < 200) begin
      cyc();
      budget++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d writes still outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.tx_full  = 1'b0;
    bus.req      = '1;
    bus.req_data = '1;
    bus.req_last = '0;
    cyc();
    cyc();
    n_cmp++;
    if (bus.wr_uart !== 1'b0 || bus.ack !== '0 || bus.w_data !== '0 || busy !== 1'b0 || grant_id !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: wr=%b ack=%b w_data=%02h busy=%b gid=%0d, required all 0",
               bus.wr_uart, bus.ack, bus.w_data, busy, grant_id);
    end
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd0 || dut.burst_cnt_q !== '0) begin
      n_bad++;
      $display("FAIL reset_state: rr_ptr=%0d burst_cnt=%0d, required 0/0", dut.rr_ptr_q, dut.burst_cnt_q);
    end
    clear_all();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_message();
    push_msg(0, 8'hA1, 3, 1'b1, 1'b1);
    n_cmp++;
    if (busy !== 1'b0 || bus.wr_uart !== 1'b0) begin
      n_bad++;
      $display("FAIL single_arb: busy=%b wr=%b in arbitration cycle, required 0/0", busy, bus.wr_uart);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_cmp++;
      if (busy !== 1'b1 || grant_id !== 2'd0 || bus.wr_uart !== 1'b1 ||
          bus.w_data !== 8'(8'hA1 + k) || bus.ack !== 4'b0001) begin
        n_bad++;
        $display("FAIL single_byte%0d: busy=%b gid=%0d wr=%b data=%02h ack=%b, required 1/0/1/%02h/0001",
                 k, busy, grant_id, bus.wr_uart, bus.w_data, bus.ack, 8'(8'hA1 + k));
      end
    end
    cyc();
    n_cmp++;
    if (busy !== 1'b0 || bus.wr_uart !== 1'b0 || dut.rr_ptr_q !== 2'd1) begin
      n_bad++;
      $display("FAIL single_release: busy=%b wr=%b rr_ptr=%0d, required 0/0/1", busy, bus.wr_uart, dut.rr_ptr_q);
    end
    check_drained("single");
  endtask

`ifndef UART_ARB_PRIORITY_EN
  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) push_msg(i, i * 16, 8, 1'b0, 1'b0);
    for (int g = 0; g < 8; g++)
      for (int k = 0; k < MAX_BURST; k++) begin
        exp_t e;
        e.id   = IW'(g % NUM_REQ);
        e.data = DBIT'((g % NUM_REQ) * 16 + (g / NUM_REQ) * MAX_BURST + k);
        exp_q.push_back(e);
      end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fair_first_idle: busy=%b, required 0", busy);
    end
    for (int g = 0; g < 8; g++) begin
      int wr_n;
      wr_n = 0;
      for (int k = 0; k < MAX_BURST; k++) begin
        cyc();
        n_cmp++;
        if (busy !== 1'b1 || grant_id !== IW'(g % NUM_REQ)) begin
          n_bad++;
          $display("FAIL fair_grant%0d: busy=%b gid=%0d, required 1/%0d", g, busy, grant_id, g % NUM_REQ);
        end
        if (bus.wr_uart === 1'b1) wr_n++;
      end
      cyc();
      n_cmp++;
      if (wr_n != MAX_BURST || busy !== 1'b0 || bus.wr_uart !== 1'b0) begin
        n_bad++;
        $display("FAIL fair_burst%0d: writes=%0d busy_after=%b, required %0d/0", g, wr_n, busy, MAX_BURST);
      end
    end
    check_drained("fair");
  endtask
`else
  task automatic test_priority();
    do_reset();
    push_msg(0, 8'hF0, 1, 1'b1, 1'b1);
    cyc();
    cyc();
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_setup: rr_ptr=%0d busy=%b, required 1/0", dut.rr_ptr_q, busy);
    end
    push_msg(0, 8'h10, 12, 1'b0, 1'b1);
    push_msg(2, 8'h20, 4, 1'b1, 1'b1);
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < MAX_BURST; k++) begin
        cyc();
        n_cmp++;
        if (busy !== 1'b1 || grant_id !== ((g < 3) ? 2'd0 : 2'd2) || bus.wr_uart !== 1'b1) begin
          n_bad++;
          $display("FAIL prio_grant%0d: busy=%b gid=%0d wr=%b, required 1/%0d/1",
                   g, busy, grant_id, bus.wr_uart, (g < 3) ? 0 : 2);
        end
      end
      cyc();
    end
    check_drained("prio");
  endtask
`endif

  task automatic test_back_pressure();
    push_msg(2, 8'hB1, 4, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_cmp++;
      if (grant_id !== 2'd2 || bus.wr_uart !== 1'b1 || bus.w_data !== 8'(8'hB1 + k)) begin
        n_bad++;
        $display("FAIL bp_pre%0d: gid=%0d wr=%b data=%02h, required 2/1/%02h",
                 k, grant_id, bus.wr_uart, bus.w_data, 8'(8'hB1 + k));
      end
    end
    @(posedge clk);
    #2;
    bus.tx_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      cyc();
      n_cmp++;
      if (busy !== 1'b1 || bus.wr_uart !== 1'b0 || bus.ack !== '0 || dut.burst_cnt_q !== 3'd2) begin
        n_bad++;
        $display("FAIL bp_stall%0d: busy=%b wr=%b ack=%b burst_cnt=%0d, required 1/0/0000/2",
                 s, busy, bus.wr_uart, bus.ack, dut.burst_cnt_q);
      end
    end
    @(posedge clk);
    #2;
    bus.tx_full = 1'b0;
    for (int k = 2; k < 4; k++) begin
      cyc();
      n_cmp++;
      if (bus.wr_uart !== 1'b1 || bus.w_data !== 8'(8'hB1 + k)) begin
        n_bad++;
        $display("FAIL bp_resume%0d: wr=%b data=%02h, required 1/%02h", k, bus.wr_uart, bus.w_data, 8'(8'hB1 + k));
      end
    end
    cyc();
    n_cmp++;
    if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd3) begin
      n_bad++;
      $display("FAIL bp_release: busy=%b rr_ptr=%0d, required 0/3", busy, dut.rr_ptr_q);
    end
    check_drained("bp");
  endtask

  task automatic test_reset_mid_grant();
    exp_t e;
    push_msg(2, 8'hE1, 3, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      e.id   = 2'd2;
      e.data = 8'(8'hE1 + k);
      exp_q.push_back(e);
    end
    cyc();
    cyc();
    n_cmp++;
    if (busy !== 1'b1 || grant_id !== 2'd2 || bus.w_data !== 8'hE2) begin
      n_bad++;
      $display("FAIL rst_mid_pre: busy=%b gid=%0d data=%02h, required 1/2/E2", busy, grant_id, bus.w_data);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.wr_uart !== 1'b0 || busy !== 1'b0 || bus.ack !== '0 || bus.w_data !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_async: wr=%b busy=%b ack=%b data=%02h, required all 0",
               bus.wr_uart, busy, bus.ack, bus.w_data);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rst_mid_sb: %0d writes outstanding, required 0", exp_q.size());
    end
    clear_all();
    cyc();
    rst_n = 1'b1;
    cyc();
    n_cmp++;
    if (grant_id !== 2'd0 || dut.rr_ptr_q !== 2'd0 || busy !== 1'b0 || bus.wr_uart !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_post: gid=%0d rr_ptr=%0d busy=%b wr=%b, required 0/0/0/0",
               grant_id, dut.rr_ptr_q, busy, bus.wr_uart);
    end
  endtask

  task automatic test_owner_abort();
    push_msg(1, 8'hC1, 2, 1'b0, 1'b1);
    push_msg(3, 8'hD1, 2, 1'b1, 1'b1);
    cyc();
    cyc();
    n_cmp++;
    if (grant_id !== 2'd1 || bus.w_data !== 8'hC2) begin
      n_bad++;
      $display("FAIL abort_owner: gid=%0d data=%02h, required 1/C2", grant_id, bus.w_data);
    end
    cyc();
    n_cmp++;
    if (busy !== 1'b1 || bus.wr_uart !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_drop: busy=%b wr=%b, required 1/0", busy, bus.wr_uart);
    end
    cyc();
    n_cmp++;
    if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd2) begin
      n_bad++;
      $display("FAIL abort_idle: busy=%b rr_ptr=%0d, required 0/2", busy, dut.rr_ptr_q);
    end
    cyc();
    n_cmp++;
    if (busy !== 1'b1 || grant_id !== 2'd3 || bus.w_data !== 8'hD1) begin
      n_bad++;
      $display("FAIL abort_next: busy=%b gid=%0d data=%02h, required 1/3/D1", busy, grant_id, bus.w_data);
    end
    cyc();
    cyc();
    n_cmp++;
    if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin
      n_bad++;
      $display("FAIL abort_wrap: busy=%b rr_ptr=%0d, required 0/0", busy, dut.rr_ptr_q);
    end
    check_drained("abort");
  endtask

  initial begin
    test_reset();
    test_single_message();
`ifndef UART_ARB_PRIORITY_EN
    test_fairness();
`endif
    test_back_pressure();
    test_reset_mid_grant();
    test_owner_abort();
`ifdef UART_ARB_PRIORITY_EN
    test_priority();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
